// File: rtl/pip_point_loader.sv
// Point-stream loader: fills POINTS {x,y} entries, then holds load_done until restart/abort; optional cksum via PIP_LOADER_CKSUM_EN.
// One point per cycle in LOAD (in_ready registered, low outside LOAD); combinational read port.
module pip_point_loader #(
  parameter  int POINTS  = 8,
  parameter  int COORD_W = 16,
  localparam int AW      = (POINTS > 1) ? $clog2(POINTS) : 1,
  localparam int CW      = $clog2(POINTS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COORD_W-1:0] in_x,
  input  logic signed [COORD_W-1:0] in_y,
  output logic                      load_done,
  input  logic [AW-1:0]             rd_addr,
  output logic signed [COORD_W-1:0] rd_x,
  output logic signed [COORD_W-1:0] rd_y,
  output logic [CW-1:0]             point_cnt
`ifdef PIP_LOADER_CKSUM_EN
  ,
  output logic [COORD_W-1:0]        cksum
`endif
);

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
  } point_t;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(POINTS - 1);

  state_t state;
  point_t mem [POINTS];
  logic   wr_en;
  logic   last_xfer;

  // Abort and reset both veto a same-edge write.
  assign wr_en     = (state == LOAD) && in_ready && in_valid && !abort && !rst;
  assign last_xfer = wr_en && (point_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      point_cnt <= '0;
      in_ready  <= 1'b0;
      load_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            point_cnt <= '0;
            in_ready  <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            state     <= IDLE;
            point_cnt <= '0;
            in_ready  <= 1'b0;
          end else if (wr_en) begin
            point_cnt <= point_cnt + CW'(1);
            if (last_xfer) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              load_done <= 1'b1;
            end
          end
        end
        DONE: begin
          if (abort) begin
            state     <= IDLE;
            point_cnt <= '0;
            load_done <= 1'b0;
          end else if (start) begin
            state     <= LOAD;
            point_cnt <= '0;
            load_done <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          point_cnt <= '0;
          in_ready  <= 1'b0;
          load_done <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately never reset so contents survive aborts and resets.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[point_cnt[AW-1:0]] <= '{x: in_x, y: in_y};
    end
  end

  generate
    if (POINTS == (1 << AW)) begin : g_rd_full
      always_comb begin
        rd_x = mem[rd_addr].x;
        rd_y = mem[rd_addr].y;
      end
    end else begin : g_rd_guard
      always_comb begin
        rd_x = '0;
        rd_y = '0;
        if ({{(32-AW){1'b0}}, rd_addr} < 32'(POINTS)) begin
          rd_x = mem[rd_addr].x;
          rd_y = mem[rd_addr].y;
        end
      end
    end
  endgenerate

`ifdef PIP_LOADER_CKSUM_EN
  logic cksum_clr;
  assign cksum_clr = ((state == IDLE) && start) ||
                     ((state == LOAD) && abort) ||
                     ((state == DONE) && (abort || start));

  always_ff @(posedge clk) begin
    if (rst || cksum_clr) begin
      cksum <= '0;
    end else if (wr_en) begin
      cksum <= cksum ^ in_x ^ in_y;
    end
  end
`endif

endmodule
